// File: rtl/frame_buffer_arbiter_if.sv
// Read-port bundle for the frame buffer arbiter: two requesters plus the BRAM read port.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface frame_buffer_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;

    logic              proc_req;
    logic [ADDR_W-1:0] proc_addr;
    logic              proc_gnt;
    logic              proc_rvalid;
    logic [DATA_W-1:0] proc_rdata;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, proc_req, proc_addr, mem_rdata,
        output disp_gnt, disp_rvalid, disp_rdata,
        output proc_gnt, proc_rvalid, proc_rdata,
        output mem_en, mem_addr
    );

    modport master (
        output disp_req, disp_addr, proc_req, proc_addr, mem_rdata,
        input  disp_gnt, disp_rvalid, disp_rdata,
        input  proc_gnt, proc_rvalid, proc_rdata,
        input  mem_en, mem_addr
    );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Frame buffer read-port arbiter: display has priority, processing is starvation-guarded
// and blocked during capture. Define FB_ARB_STATS_EN to build the processing stall counter.
//
// state      | meaning
// NORMAL     | display first, processing when display idle
// FORCE_PROC | one cycle where a waiting processing request beats display
// LOCKED     | capture in progress, display-only grants
module frame_buffer_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 16,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   capture_busy,
    frame_buffer_arbiter_if.slave  bus,
    output logic [15:0]            proc_stall_cnt
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        NORMAL     = 2'd0,
        FORCE_PROC = 2'd1,
        LOCKED     = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  starve_cnt;
    logic              proc_ok;
    logic              disp_gnt;
    logic              proc_gnt;
    logic [1:0]        tag_pipe [RD_LAT];
    logic [DATA_W-1:0] rdata;

    // Grants are combinational so a request is accepted in the cycle it is presented.
    always_comb begin
        proc_ok  = bus.proc_req & ~capture_busy;
        disp_gnt = 1'b0;
        proc_gnt = 1'b0;
        if (!reset) begin
            case (state)
                LOCKED: begin
                    disp_gnt = bus.disp_req;
                end
                FORCE_PROC: begin
                    if (proc_ok)
                        proc_gnt = 1'b1;
                    else if (bus.disp_req)
                        disp_gnt = 1'b1;
                end
                default: begin
                    if (bus.disp_req)
                        disp_gnt = 1'b1;
                    else if (proc_ok)
                        proc_gnt = 1'b1;
                end
            endcase
        end
    end

    assign bus.disp_gnt = disp_gnt;
    assign bus.proc_gnt = proc_gnt;
    assign bus.mem_en   = disp_gnt | proc_gnt;
    assign bus.mem_addr = disp_gnt ? bus.disp_addr :
                          proc_gnt ? bus.proc_addr : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else if (capture_busy) begin
            state      <= LOCKED;
            starve_cnt <= '0;
        end else if (state == LOCKED) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state <= NORMAL;
            if (proc_gnt || !bus.proc_req) begin
                starve_cnt <= '0;
            end else if (disp_gnt) begin
                // capture_busy is low here, so a display grant means processing was passed over
                if (starve_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                    state      <= FORCE_PROC;
                    starve_cnt <= '0;
                end else begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Tag pipeline mirrors the BRAM latency; bit 1 = display, bit 0 = processing.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= 2'b00;
        end else begin
            tag_pipe[0] <= {disp_gnt, proc_gnt};
            for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign rdata           = bus.mem_rdata;
    assign bus.disp_rvalid = tag_pipe[RD_LAT-1][1] & ~reset;
    assign bus.proc_rvalid = tag_pipe[RD_LAT-1][0] & ~reset;
    assign bus.disp_rdata  = rdata;
    assign bus.proc_rdata  = rdata;

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= '0;
        else if (bus.proc_req && !proc_gnt && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign proc_stall_cnt = reset ? 16'd0 : stall_q;
`else
    assign proc_stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: RD_LAT=1 and RD_LAT=3 instances share one stimulus,
// checked every cycle against a rule-level model plus hand-computed literals.
module tb_frame_buffer_arbiter;
    localparam int AW    = 17;
    localparam int DW    = 16;
    localparam int LIMIT = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, capture_busy, disp_req, proc_req;
    logic [AW-1:0] disp_addr, proc_addr;
    logic [15:0]   stall1, stall3;

    frame_buffer_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    frame_buffer_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    assign bus1.disp_req  = disp_req;
    assign bus1.disp_addr = disp_addr;
    assign bus1.proc_req  = proc_req;
    assign bus1.proc_addr = proc_addr;
    assign bus3.disp_req  = disp_req;
    assign bus3.disp_addr = disp_addr;
    assign bus3.proc_req  = proc_req;
    assign bus3.proc_addr = proc_addr;

    frame_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_LIMIT(LIMIT)) u_dut1 (
        .clk(clk), .reset(reset), .capture_busy(capture_busy),
        .bus(bus1.slave), .proc_stall_cnt(stall1));

    frame_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_LIMIT(LIMIT)) u_dut3 (
        .clk(clk), .reset(reset), .capture_busy(capture_busy),
        .bus(bus3.slave), .proc_stall_cnt(stall3));

    function automatic logic [15:0] pix(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    // BRAM models with 1 and 3 cycle read latency
    logic [15:0] m1;
    logic [15:0] m3 [3];
    always @(posedge clk) begin
        m1    <= bus1.mem_en ? pix(bus1.mem_addr) : 16'hDEAD;
        m3[0] <= bus3.mem_en ? pix(bus3.mem_addr) : 16'hDEAD;
        m3[1] <= m3[0];
        m3[2] <= m3[1];
    end
    assign bus1.mem_rdata = m1;
    assign bus3.mem_rdata = m3[2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model state
    bit            m_locked = 0;
    bit            m_force  = 0;
    int            m_streak = 0;
    int            m_stall  = 0;
    int            last_reset = -100;
    bit            hd [8] = '{default: 1'b0};
    bit            hp [8] = '{default: 1'b0};
    logic [AW-1:0] ha [8] = '{default: '0};

    // snapshots taken at the compare point
    logic          s_dg, s_pg, s_me;
    logic [AW-1:0] s_ma;
    logic          s_dv1, s_pv1, s_dv3, s_pv3;
    logic [15:0]   s_dd1, s_dd3, s_pd3;
    logic [15:0]   s_st1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_rv(input string tag, input int lat, input logic dv, input logic pv,
                          input logic [15:0] dd, input logic [15:0] pd);
        int            g;
        bit            ed, ep;
        logic [AW-1:0] a;
        g  = cyc - lat;
        ed = 1'b0;
        ep = 1'b0;
        a  = '0;
        if (g >= 0 && last_reset < g) begin
            ed = hd[g % 8];
            ep = hp[g % 8];
            a  = ha[g % 8];
        end
        check({tag, ".disp_rvalid"}, 32'(dv), 32'(ed));
        check({tag, ".proc_rvalid"}, 32'(pv), 32'(ep));
        if (ed) check({tag, ".disp_rdata"}, 32'(dd), 32'(pix(a)));
        if (ep) check({tag, ".proc_rdata"}, 32'(pd), 32'(pix(a)));
    endtask

    // One clock cycle: compare at negedge, advance model, return just after posedge.
    task automatic step();
        bit            pok, eg_d, eg_p;
        logic [AW-1:0] e_addr;
        int            e_stall;
        @(negedge clk);
        pok  = proc_req & ~capture_busy;
        eg_d = 1'b0;
        eg_p = 1'b0;
        if (!reset) begin
            if (m_locked)            eg_d = disp_req;
            else if (m_force && pok) eg_p = 1'b1;
            else if (disp_req)       eg_d = 1'b1;
            else if (pok)            eg_p = 1'b1;
        end
        e_addr = eg_d ? disp_addr : (eg_p ? proc_addr : '0);
        if (reset) last_reset = cyc;
        hd[cyc % 8] = eg_d;
        hp[cyc % 8] = eg_p;
        ha[cyc % 8] = e_addr;
`ifdef FB_ARB_STATS_EN
        e_stall = reset ? 0 : m_stall;
`else
        e_stall = 0;
`endif
        check("l1.disp_gnt", 32'(bus1.disp_gnt), 32'(eg_d));
        check("l1.proc_gnt", 32'(bus1.proc_gnt), 32'(eg_p));
        check("l1.mem_en",   32'(bus1.mem_en),   32'(eg_d | eg_p));
        check("l1.mem_addr", 32'(bus1.mem_addr), 32'(e_addr));
        check("l3.disp_gnt", 32'(bus3.disp_gnt), 32'(eg_d));
        check("l3.proc_gnt", 32'(bus3.proc_gnt), 32'(eg_p));
        check("l3.mem_en",   32'(bus3.mem_en),   32'(eg_d | eg_p));
        check("l3.mem_addr", 32'(bus3.mem_addr), 32'(e_addr));
        chk_rv("l1", 1, bus1.disp_rvalid, bus1.proc_rvalid, bus1.disp_rdata, bus1.proc_rdata);
        chk_rv("l3", 3, bus3.disp_rvalid, bus3.proc_rvalid, bus3.disp_rdata, bus3.proc_rdata);
        check("l1.stall_cnt", 32'(stall1), 32'(e_stall));
        check("l3.stall_cnt", 32'(stall3), 32'(e_stall));

        s_dg  = bus1.disp_gnt;    s_pg  = bus1.proc_gnt;
        s_me  = bus1.mem_en;      s_ma  = bus1.mem_addr;
        s_dv1 = bus1.disp_rvalid; s_pv1 = bus1.proc_rvalid; s_dd1 = bus1.disp_rdata;
        s_dv3 = bus3.disp_rvalid; s_pv3 = bus3.proc_rvalid;
        s_dd3 = bus3.disp_rdata;  s_pd3 = bus3.proc_rdata;
        s_st1 = stall1;

        // Locked exactly when capture_busy was seen high last cycle; streak counts
        // display grants that passed over an eligible processing request.
        if (reset) m_stall = 0;
        else if (proc_req && !eg_p && m_stall < 65535) m_stall++;
        m_force = 1'b0;
        if (reset || capture_busy || m_locked) begin
            m_streak = 0;
        end else if (eg_p || !proc_req) begin
            m_streak = 0;
        end else if (eg_d) begin
            m_streak++;
            if (m_streak == LIMIT) begin
                m_force  = 1'b1;
                m_streak = 0;
            end
        end
        m_locked = !reset && capture_busy;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] t1_data [4] = '{16'hC3C3, 16'hC3C2, 16'hC3C1, 16'hC3C0};
    int nd, np, npv, first, nrv;

    initial begin
        reset = 1'b1; capture_busy = 1'b0;
        disp_req = 1'b0; proc_req = 1'b0;
        disp_addr = '0; proc_addr = '0;
        repeat (3) step();
        check("rst_outputs_zero", 32'({s_dg, s_pg, s_me, s_dv1, s_pv1, s_dv3, s_pv3}), 32'd0);
        check("rst_mem_addr", 32'(s_ma), 32'd0);
        reset = 1'b0;
        step();

        // display-only burst, addresses 0..3
        for (int i = 0; i < 4; i++) begin
            disp_req = 1'b1; disp_addr = AW'(i);
            step();
            check("t1_disp_gnt", 32'(s_dg), 32'd1);
            check("t1_mem_addr", 32'(s_ma), 32'(i));
            if (i > 0) begin
                check("t1_rvalid", 32'(s_dv1), 32'd1);
                check("t1_rdata", 32'(s_dd1), 32'(t1_data[i-1]));
            end
        end
        disp_req = 1'b0; disp_addr = '0;
        step();
        check("t1_rvalid_last", 32'(s_dv1), 32'd1);
        check("t1_rdata_last", 32'(s_dd1), 32'hC3C0);
        step();

        // both saturating: 8 display, 1 processing, repeating
        disp_req = 1'b1; proc_req = 1'b1;
        disp_addr = 17'h100; proc_addr = 17'h200;
        nd = 0; np = 0; npv = 0; first = -1;
        for (int k = 0; k < 27; k++) begin
            step();
            nd += int'(s_dg); np += int'(s_pg); npv += int'(s_pv1);
            if (s_pg && first < 0) first = k;
        end
        disp_req = 1'b0; proc_req = 1'b0;
        step();
        npv += int'(s_pv1);
        check("t2_disp_grants", 32'(nd), 32'd24);
        check("t2_proc_grants", 32'(np), 32'd3);
        check("t2_first_proc", 32'(first), 32'd8);
        check("t2_proc_rvalids", 32'(npv), 32'd3);
        step();

        // RD_LAT=3 alternating traffic
        disp_req = 1'b1; disp_addr = 17'h10;
        step();
        disp_req = 1'b0; proc_req = 1'b1; proc_addr = 17'h20;
        step();
        proc_req = 1'b0; disp_req = 1'b1; disp_addr = 17'h11;
        step();
        disp_req = 1'b0;
        step();
        check("t4_c3_disp_rvalid", 32'({s_dv3, s_pv3}), 32'b10);
        check("t4_c3_data", 32'(s_dd3), 32'hC3D3);
        step();
        check("t4_c4_proc_rvalid", 32'({s_dv3, s_pv3}), 32'b01);
        check("t4_c4_data", 32'(s_pd3), 32'hC3E3);
        step();
        check("t4_c5_disp_rvalid", 32'({s_dv3, s_pv3}), 32'b10);
        check("t4_c5_data", 32'(s_dd3), 32'hC3D2);
        step();

        // reset one cycle after two grants discards in-flight reads
        disp_req = 1'b1; disp_addr = 17'h30;
        step();
        disp_addr = 17'h31;
        step();
        disp_req = 1'b0; reset = 1'b1;
        step();
        check("t5_reset_outputs", 32'({s_dg, s_pg, s_me, s_dv1, s_pv1, s_dv3, s_pv3}), 32'd0);
        reset = 1'b0;
        nrv = 0;
        repeat (5) begin
            step();
            nrv += int'(s_dv1) + int'(s_pv1) + int'(s_dv3) + int'(s_pv3);
        end
        check("t5_no_rvalid", 32'(nrv), 32'd0);

        // capture blocks processing; grant once LOCKED is left
        proc_req = 1'b1; proc_addr = 17'h40; capture_busy = 1'b1;
        first = -1;
        for (int k = 0; k < 10; k++) begin
            if (k == 5) capture_busy = 1'b0;
            step();
            if (s_pg && first < 0) begin
                first = k;
                proc_req = 1'b0;
            end
        end
        check("t3_first_proc", 32'(first), 32'd6);
`ifdef FB_ARB_STATS_EN
        check("t3_stall_cnt", 32'(s_st1), 32'd6);
`else
        check("t3_stall_cnt", 32'(s_st1), 32'd0);
`endif

`ifdef FB_ARB_STATS_EN
        // long saturation: stall counter must pin at 0xFFFF
        disp_req = 1'b1; proc_req = 1'b1;
        disp_addr = 17'h1_2345; proc_addr = 17'h0_0ABC;
        repeat (75000) step();
        check("t6_stall_sat", 32'(s_st1), 32'h0000FFFF);
        disp_req = 1'b0; proc_req = 1'b0;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
